// File: rtl/lock_attempt_controller_pkg.sv
// Shared types and default constants for the lock attempt controller.
// The state encoding and default timings are visible to the RTL and to any bench that imports them.
package lock_attempt_controller_pkg;

  localparam int MAX_FAILS_DEF      = 3;
  localparam int UNLOCK_CYCLES_DEF  = 8;
  localparam int LOCKOUT_CYCLES_DEF = 16;
  localparam int CNT_W_DEF          = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_LOCKOUT = 3'd4
  } lock_state_e;

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that stops at zero and never wraps.
// A load always wins over counting.
module lock_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lock_attempt_controller.sv
// Samples the lock match bit on each accepted try, then drives a timed unlock,
// a fail pulse, or a timed lockout with alarm after too many consecutive misses.
module lock_attempt_controller
  import lock_attempt_controller_pkg::*;
#(
  parameter int MAX_FAILS      = MAX_FAILS_DEF,
  parameter int UNLOCK_CYCLES  = UNLOCK_CYCLES_DEF,
  parameter int LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       try_i,
  input  logic       z_i,
  output logic       ready_o,
  output logic       unlock_o,
  output logic       fail_o,
  output logic       lockout_o,
  output logic       alarm_o,
  output logic [1:0] fail_cnt_o
);

  localparam logic [1:0]       MAX_C     = 2'(MAX_FAILS);
  localparam logic [CNT_W-1:0] UNLOCK_LD = CNT_W'(UNLOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LD   = CNT_W'(LOCKOUT_CYCLES - 1);

  lock_state_e      state_q, state_d;
  logic [1:0]       fail_cnt_q, fail_cnt_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic [CNT_W-1:0] tmr_cnt;
  logic             tmr_zero;
  logic             tmr_en;

  assign tmr_en = (state_q == ST_OPEN) || (state_q == ST_LOCKOUT);

  lock_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .en_i       (tmr_en),
    .load_val_i (tmr_load_val),
    .cnt_o      (tmr_cnt),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fail_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  // In CHECK, fail_cnt_q is always below MAX_C, so the +1 cannot overflow.
  always_comb begin
    state_d      = state_q;
    fail_cnt_d   = fail_cnt_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    case (state_q)
      ST_IDLE: begin
        if (try_i) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (z_i) begin
          state_d      = ST_OPEN;
          fail_cnt_d   = 2'd0;
          tmr_load     = 1'b1;
          tmr_load_val = UNLOCK_LD;
        end else if ((fail_cnt_q + 2'd1) < MAX_C) begin
          state_d    = ST_FAIL;
          fail_cnt_d = fail_cnt_q + 2'd1;
        end else begin
          state_d      = ST_LOCKOUT;
          fail_cnt_d   = MAX_C;
          tmr_load     = 1'b1;
          tmr_load_val = LOCK_LD;
        end
      end
      ST_OPEN: begin
        if (tmr_zero) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OPEN;
        end
      end
      ST_FAIL: begin
        state_d = ST_IDLE;
      end
      ST_LOCKOUT: begin
        if (tmr_zero) begin
          state_d    = ST_IDLE;
          fail_cnt_d = 2'd0;
        end else begin
          state_d = ST_LOCKOUT;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        fail_cnt_d = 2'd0;
      end
    endcase
  end

  assign ready_o    = (state_q == ST_IDLE);
  assign unlock_o   = (state_q == ST_OPEN);
  assign fail_o     = (state_q == ST_FAIL);
  assign lockout_o  = (state_q == ST_LOCKOUT);
  assign alarm_o    = (state_q == ST_LOCKOUT) && (tmr_cnt == LOCK_LD);
  assign fail_cnt_o = fail_cnt_q;

endmodule

// File: tb/tb_lock_attempt_controller.sv
// Directed and random checks of lock_attempt_controller against a schedule-based model:
// each accepted try queues the predicted per-cycle output pattern of its outcome.
module tb_lock_attempt_controller;

  localparam int N_FAILS = 3;
  localparam int N_OPEN  = 8;
  localparam int N_LOCK  = 16;

  logic       clk;
  logic       rst;
  logic       try_s;
  logic       z_s;
  logic       ready_s, unlock_s, fail_s, lockout_s, alarm_s;
  logic [1:0] fail_cnt_s;

  int n_cmp;
  int n_bad;

  logic [6:0] cur;
  logic [6:0] sched[$];
  bit         checking;
  int         fails;

  lock_attempt_controller dut (
    .clk        (clk),
    .rst        (rst),
    .try_i      (try_s),
    .z_i        (z_s),
    .ready_o    (ready_s),
    .unlock_o   (unlock_s),
    .fail_o     (fail_s),
    .lockout_o  (lockout_s),
    .alarm_o    (alarm_s),
    .fail_cnt_o (fail_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] vec(input bit r, input bit u, input bit f,
                                     input bit l, input bit a, input int c);
    return {r, u, f, l, a, 2'(c)};
  endfunction

  task automatic model_reset();
    sched.delete();
    checking = 1'b0;
    fails    = 0;
    cur      = vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  // Advance the model by one clock edge using the inputs held at that edge.
  task automatic model_edge();
    logic [6:0] nxt;
    if (checking) begin
      checking = 1'b0;
      if (z_s) begin
        fails = 0;
        for (int i = 0; i < N_OPEN; i++) sched.push_back(vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
      end else if (fails + 1 < N_FAILS) begin
        fails = fails + 1;
        sched.push_back(vec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, fails));
      end else begin
        for (int i = 0; i < N_LOCK; i++) sched.push_back(vec(1'b0, 1'b0, 1'b0, 1'b1, (i == 0), N_FAILS));
        fails = 0;
      end
      nxt = sched.pop_front();
    end else if (cur[6] && try_s) begin
      checking = 1'b1;
      nxt = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fails);
    end else if (sched.size() > 0) begin
      nxt = sched.pop_front();
    end else begin
      nxt = vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, fails);
    end
    cur = nxt;
  endtask

  task automatic check(input string tag);
    logic [6:0] obs;
    obs = {ready_s, unlock_s, fail_s, lockout_s, alarm_s, fail_cnt_s};
    n_cmp++;
    assert (obs === cur) else begin
      n_bad++;
      $error("FAIL %s observed={rdy,unl,fail,lock,alm,cnt}=%b expected=%b", tag, obs, cur);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check(tag);
  endtask

  task automatic run(input int n, input logic t, input logic z, input string tag);
    try_s = t;
    z_s   = z;
    for (int i = 0; i < n; i++) step(tag);
  endtask

  // Called about 1 time unit after a rising edge, so assert and release stay clear of edges.
  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check({tag, "_async"});
    @(posedge clk);
    #1;
    check({tag, "_held"});
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    try_s = 1'b0;
    z_s   = 1'b0;
    model_reset();
    #2;
    check("reset_state");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: single matching try
    run(1, 1'b1, 1'b1, "t1_try");
    run(1, 1'b0, 1'b1, "t1_check");
    run(10, 1'b0, 1'b0, "t1_open");

    // 2: three misses in a row lead to lockout
    for (int k = 0; k < 3; k++) begin
      run(1, 1'b1, 1'b0, "t2_try");
      run(1, 1'b0, 1'b0, "t2_check");
      run(2, 1'b0, 1'b0, "t2_after");
    end
    run(N_LOCK + 2, 1'b0, 1'b0, "t2_lockout");

    // 3: two misses, a match clears the count, two more misses do not lock
    for (int k = 0; k < 2; k++) begin
      run(1, 1'b1, 1'b0, "t3_miss");
      run(2, 1'b0, 1'b0, "t3_miss_w");
    end
    run(1, 1'b1, 1'b1, "t3_match");
    run(N_OPEN + 2, 1'b0, 1'b1, "t3_open");
    for (int k = 0; k < 2; k++) begin
      run(1, 1'b1, 1'b0, "t3_miss2");
      run(2, 1'b0, 1'b0, "t3_miss2_w");
    end

    // 4: try pulses during OPEN and LOCKOUT, then try held high
    run(1, 1'b1, 1'b1, "t4_match");
    run(1, 1'b0, 1'b1, "t4_check");
    for (int k = 0; k < 4; k++) begin
      run(1, 1'b1, 1'b0, "t4_open_try");
      run(1, 1'b0, 1'b0, "t4_open_idle");
    end
    run(3, 1'b0, 1'b0, "t4_open_end");
    run(1, 1'b1, 1'b0, "t4_lock_try");
    run(2, 1'b0, 1'b0, "t4_lock_chk");
    for (int k = 0; k < 8; k++) begin
      run(1, 1'b1, 1'b0, "t4_lock_try");
      run(1, 1'b0, 1'b0, "t4_lock_idle");
    end
    run(3, 1'b0, 1'b0, "t4_lock_end");
    run(2 * N_OPEN + 8, 1'b1, 1'b1, "t4_held");

    // 5: z high only outside CHECK counts as a miss
    run(1, 1'b0, 1'b0, "t5_idle");
    run(1, 1'b1, 1'b1, "t5_try_zhi");
    run(1, 1'b0, 1'b0, "t5_check_zlo");
    run(1, 1'b0, 1'b1, "t5_after");
    run(2, 1'b0, 1'b0, "t5_idle2");

    // 6: reset part way through a lockout, then a normal unlock
    for (int k = 0; k < 3; k++) begin
      run(1, 1'b1, 1'b0, "t6_miss");
      run(1, 1'b0, 1'b0, "t6_miss_w");
    end
    run(5, 1'b0, 1'b0, "t6_lock");
    pulse_reset("t6_rst");
    run(2, 1'b0, 1'b0, "t6_post");
    run(1, 1'b1, 1'b1, "t6_match");
    run(N_OPEN + 3, 1'b0, 1'b1, "t6_open");

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      try_s = ($urandom_range(0, 3) == 0);
      z_s   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 249) == 0) begin
        pulse_reset("rnd_rst");
      end else begin
        step("rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
